// File: rtl/ladder_tick_gen.sv
// ============================================================================
// Module      : ladder_tick_gen
// Description : 1 kHz time base for ladder timers, with a programmable divisor,
//               a tick strobe, a ms counter and an optional decade strobe cascade.
//               The cascade is built only when TICK_DECADE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ladder_tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cfg_valid,
    input  logic [31:0] cfg_div,
    output logic        cfg_ready,
    output logic [31:0] div_cur,
    output logic        tick,
    output logic        tick_stb,
    output logic        tick_10ms_stb,
    output logic        tick_100ms_stb,
    output logic        tick_1s_stb,
    output logic [31:0] ms_count
);

    localparam logic [31:0] C_DIV_RAW = 32'(CLK_HZ / TICK_HZ);
    localparam logic [31:0] C_DIV_RST = (C_DIV_RAW < 32'd2) ? 32'd2 : C_DIV_RAW;

    logic [31:0] r_ph;
    logic [31:0] r_pend_div;
    logic        r_pend_valid;

    logic [31:0] w_half;
    logic        w_wrap;
    logic        w_fall;
    logic        w_xfer;
    logic        w_apply;
    logic [31:0] w_cfg_clamped;

    assign w_half        = div_cur >> 1;
    assign w_wrap        = en && (r_ph == (div_cur - 32'd1));
    assign w_fall        = en && (r_ph == (w_half - 32'd1));
    assign w_xfer        = cfg_valid && cfg_ready;
    // A pending divisor takes effect on a period boundary, or at once while idle.
    assign w_apply       = r_pend_valid && (w_wrap || !en);
    assign w_cfg_clamped = (cfg_div < 32'd2) ? 32'd2 : cfg_div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ph         <= 32'd0;
            tick         <= 1'b0;
            tick_stb     <= 1'b0;
            ms_count     <= 32'd0;
            div_cur      <= C_DIV_RST;
            r_pend_div   <= 32'd0;
            r_pend_valid <= 1'b0;
            cfg_ready    <= 1'b1;
        end else begin
            if (!en || w_wrap) begin
                r_ph <= 32'd0;
            end else begin
                r_ph <= r_ph + 32'd1;
            end

            if (!en) begin
                tick <= 1'b0;
            end else if (w_wrap) begin
                tick <= 1'b1;
            end else if (w_fall) begin
                tick <= 1'b0;
            end

            tick_stb <= w_wrap;
            ms_count <= ms_count + {31'd0, w_wrap};

            // cfg_ready is low exactly while a divisor is pending, so apply and
            // transfer never coincide.
            if (w_apply) begin
                div_cur      <= r_pend_div;
                r_pend_valid <= 1'b0;
                cfg_ready    <= 1'b1;
            end else if (w_xfer) begin
                r_pend_div   <= w_cfg_clamped;
                r_pend_valid <= 1'b1;
                cfg_ready    <= 1'b0;
            end
        end
    end

`ifdef TICK_DECADE_EN
    logic [3:0] r_c10;
    logic [3:0] r_c100;
    logic [3:0] r_c1s;
    logic       w_c10_wrap;
    logic       w_c100_wrap;
    logic       w_c1s_wrap;

    assign w_c10_wrap  = w_wrap && (r_c10 == 4'd9);
    assign w_c100_wrap = w_c10_wrap && (r_c100 == 4'd9);
    assign w_c1s_wrap  = w_c100_wrap && (r_c1s == 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c10          <= 4'd0;
            r_c100         <= 4'd0;
            r_c1s          <= 4'd0;
            tick_10ms_stb  <= 1'b0;
            tick_100ms_stb <= 1'b0;
            tick_1s_stb    <= 1'b0;
        end else begin
            tick_10ms_stb  <= w_c10_wrap;
            tick_100ms_stb <= w_c100_wrap;
            tick_1s_stb    <= w_c1s_wrap;
            if (w_wrap) begin
                r_c10 <= w_c10_wrap ? 4'd0 : r_c10 + 4'd1;
            end
            if (w_c10_wrap) begin
                r_c100 <= w_c100_wrap ? 4'd0 : r_c100 + 4'd1;
            end
            if (w_c100_wrap) begin
                r_c1s <= w_c1s_wrap ? 4'd0 : r_c1s + 4'd1;
            end
        end
    end
`else
    assign tick_10ms_stb  = 1'b0;
    assign tick_100ms_stb = 1'b0;
    assign tick_1s_stb    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ladder_tick_gen.sv
// ============================================================================
// Module      : tb_ladder_tick_gen
// Description : Directed self-checking bench for ladder_tick_gen (divisor 10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ladder_tick_gen;

`ifdef TICK_DECADE_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic [31:0] cfg_div;
    logic        cfg_ready;
    logic [31:0] div_cur;
    logic        tick;
    logic        tick_stb;
    logic        tick_10ms_stb;
    logic        tick_100ms_stb;
    logic        tick_1s_stb;
    logic [31:0] ms_count;

    int n_chk  = 0;
    int n_fail = 0;

    ladder_tick_gen #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_div       (cfg_div),
        .cfg_ready     (cfg_ready),
        .div_cur       (div_cur),
        .tick          (tick),
        .tick_stb      (tick_stb),
        .tick_10ms_stb (tick_10ms_stb),
        .tick_100ms_stb(tick_100ms_stb),
        .tick_1s_stb   (tick_1s_stb),
        .ms_count      (ms_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = 32'd0;
        step(2);
        chk("rst_tick",  {31'd0, tick}, 32'd0);
        chk("rst_stb",   {31'd0, tick_stb}, 32'd0);
        chk("rst_ms",    ms_count, 32'd0);
        chk("rst_div",   div_cur, 32'd10);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_dec",   {29'd0, tick_10ms_stb, tick_100ms_stb, tick_1s_stb}, 32'd0);

        // Base period; edge numbers count from reset release.
        rst = 1'b1;
        step(9);   // edge 9
        chk("base_e9_stb",  {31'd0, tick_stb}, 32'd0);
        chk("base_e9_tick", {31'd0, tick}, 32'd0);
        step(1);   // edge 10
        chk("base_e10_stb",  {31'd0, tick_stb}, 32'd1);
        chk("base_e10_tick", {31'd0, tick}, 32'd1);
        chk("base_e10_ms",   ms_count, 32'd1);
        step(4);   // edge 14
        chk("base_e14_tick", {31'd0, tick}, 32'd1);
        chk("base_e14_stb",  {31'd0, tick_stb}, 32'd0);
        step(1);   // edge 15
        chk("base_e15_tick", {31'd0, tick}, 32'd0);
        step(5);   // edge 20
        chk("base_e20_stb", {31'd0, tick_stb}, 32'd1);
        chk("base_e20_ms",  ms_count, 32'd2);
        step(10);  // edge 30
        chk("base_e30_stb", {31'd0, tick_stb}, 32'd1);
        chk("base_e30_ms",  ms_count, 32'd3);

        // Divisor change offered at ph=3.
        step(3);   // edge 33
        chk("chg_ready_pre", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_div   = 32'd4;
        step(1);   // edge 34: transfer
        cfg_valid = 1'b0;
        chk("chg_ready_low", {31'd0, cfg_ready}, 32'd0);
        chk("chg_div_old",   div_cur, 32'd10);
        step(5);   // edge 39
        chk("chg_e39_stb", {31'd0, tick_stb}, 32'd0);
        step(1);   // edge 40: period completes, divisor applied
        chk("chg_e40_div", div_cur, 32'd4);
        chk("chg_e40_stb", {31'd0, tick_stb}, 32'd1);
        chk("chg_e40_ms",  ms_count, 32'd4);
        step(1);   // edge 41
        chk("chg_e41_tick",  {31'd0, tick}, 32'd1);
        chk("chg_e41_ready", {31'd0, cfg_ready}, 32'd1);
        step(1);   // edge 42
        chk("chg_e42_tick", {31'd0, tick}, 32'd0);
        step(2);   // edge 44
        chk("chg_e44_stb",  {31'd0, tick_stb}, 32'd1);
        chk("chg_e44_tick", {31'd0, tick}, 32'd1);
        chk("chg_e44_ms",   ms_count, 32'd5);

        // Clamp: a divisor of 1 becomes 2.
        cfg_valid = 1'b1;
        cfg_div   = 32'd1;
        step(1);   // edge 45: transfer
        cfg_valid = 1'b0;
        step(3);   // edge 48
        chk("clamp_div",     div_cur, 32'd2);
        chk("clamp_e48_stb", {31'd0, tick_stb}, 32'd1);
        chk("clamp_e48_ms",  ms_count, 32'd6);
        step(1);   // edge 49
        chk("clamp_e49_tick", {31'd0, tick}, 32'd0);
        chk("clamp_e49_stb",  {31'd0, tick_stb}, 32'd0);
        step(1);   // edge 50
        chk("clamp_e50_tick", {31'd0, tick}, 32'd1);
        chk("clamp_e50_stb",  {31'd0, tick_stb}, 32'd1);
        step(1);   // edge 51
        chk("clamp_e51_tick", {31'd0, tick}, 32'd0);

        // Back to 10, transferred on the same edge as a wrap.
        cfg_valid = 1'b1;
        cfg_div   = 32'd10;
        step(1);   // edge 52: wrap + transfer
        cfg_valid = 1'b0;
        chk("same_e52_stb", {31'd0, tick_stb}, 32'd1);
        chk("same_e52_div", div_cur, 32'd2);
        step(1);   // edge 53
        chk("same_e53_div",   div_cur, 32'd2);
        chk("same_e53_ready", {31'd0, cfg_ready}, 32'd0);
        step(1);   // edge 54: next wrap applies it
        chk("same_e54_div", div_cur, 32'd10);
        chk("same_e54_ms",  ms_count, 32'd9);

        // Enable drop at ph=7 for three edges.
        step(7);   // edge 61
        en = 1'b0;
        step(1);   // edge 62
        chk("en_e62_tick", {31'd0, tick}, 32'd0);
        chk("en_e62_stb",  {31'd0, tick_stb}, 32'd0);
        chk("en_e62_ms",   ms_count, 32'd9);
        step(2);   // edge 64
        chk("en_e64_tick", {31'd0, tick}, 32'd0);
        chk("en_e64_ms",   ms_count, 32'd9);
        en = 1'b1;
        step(9);   // edge 73
        chk("en_e73_stb", {31'd0, tick_stb}, 32'd0);
        chk("en_e73_ms",  ms_count, 32'd9);
        step(1);   // edge 74
        chk("en_e74_stb",  {31'd0, tick_stb}, 32'd1);
        chk("en_e74_tick", {31'd0, tick}, 32'd1);
        chk("en_e74_ms",   ms_count, 32'd10);

        // Reset asserted between clock edges while a divisor is pending.
        cfg_valid = 1'b1;
        cfg_div   = 32'd4;
        step(1);   // edge 75: transfer
        cfg_valid = 1'b0;
        step(1);   // edge 76
        chk("mid_pre_tick",  {31'd0, tick}, 32'd1);
        chk("mid_pre_ready", {31'd0, cfg_ready}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_tick",  {31'd0, tick}, 32'd0);
        chk("mid_ms",    ms_count, 32'd0);
        chk("mid_div",   div_cur, 32'd10);
        chk("mid_ready", {31'd0, cfg_ready}, 32'd1);
        step(2);
        rst = 1'b1;
        step(9);
        chk("mid_rel_e9_stb", {31'd0, tick_stb}, 32'd0);
        step(1);
        chk("mid_rel_e10_stb",  {31'd0, tick_stb}, 32'd1);
        chk("mid_rel_e10_tick", {31'd0, tick}, 32'd1);
        step(1);
        chk("mid_rel_e11_div", div_cur, 32'd10);

        // Decade cascade over 1000 ticks from a fresh reset.
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            step(9);
            chk("dec_gap_10ms", {31'd0, tick_10ms_stb}, 32'd0);
            step(1);
            chk("dec_stb",   {31'd0, tick_stb}, 32'd1);
            chk("dec_10ms",  {31'd0, tick_10ms_stb},  {31'd0, DEC_EN && (n % 10 == 0)});
            chk("dec_100ms", {31'd0, tick_100ms_stb}, {31'd0, DEC_EN && (n % 100 == 0)});
            chk("dec_1s",    {31'd0, tick_1s_stb},    {31'd0, DEC_EN && (n == 1000)});
        end
        chk("dec_ms", ms_count, 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
